// File: rtl/touch_adc_pkg.sv
// +-----------------------------------------------------------------------------
// | touch_adc_pkg : shared state encoding and command-field layout for the
// |                 resistive-touch ADC responder.
// | Revision      : 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

package touch_adc_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HUNT      = 3'd1,
        CMD       = 3'd2,
        BUSY_WAIT = 3'd3,
        BUSY      = 3'd4,
        DATA      = 3'd5
    } state_t;

    localparam logic [2:0] CH_X  = 3'b101;
    localparam logic [2:0] CH_Y  = 3'b001;
    localparam logic [2:0] CH_Z1 = 3'b011;
    localparam logic [2:0] CH_Z2 = 3'b100;

    // Command byte layout, MSB first on the wire: S A2 A1 A0 MODE SER PD1 PD0
    localparam int CMD_ADDR_MSB = 6;
    localparam int CMD_ADDR_LSB = 4;
    localparam int CMD_MODE_BIT = 3;
    localparam int CMD_LEN      = 8;

endpackage

`default_nettype wire

// File: rtl/touch_edge_sync.sv
// +-----------------------------------------------------------------------------
// | touch_edge_sync : multi-stage synchronizer with single-cycle rise/fall pulses.
// | Revision        : 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module touch_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic cclk,
    input  logic rstb,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_async};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign o_sync = sync_q[SYNC_STAGES-1];
    assign o_rise =  sync_q[SYNC_STAGES-1] & ~prev_q;
    assign o_fall = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

`default_nettype wire

// File: rtl/touch_adc_responder.sv
// +-----------------------------------------------------------------------------
// | touch_adc_responder : ADS7843/TSC2046-style serial responder returning fabric
// |                       X/Y/Z1/Z2 values. Define TOUCH_PENIRQ_EN for pen IRQ.
// | Revision            : 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module touch_adc_responder
    import touch_adc_pkg::*;
#(
    parameter int                   DATA_BITS     = 12,
    parameter int                   SYNC_STAGES   = 2,
    parameter logic [DATA_BITS-1:0] PEN_THRESHOLD = 256
) (
    input  logic                 cclk,
    input  logic                 rstb,
    input  logic                 touch_clk,
    input  logic                 touch_csb,
    input  logic                 touch_data_in,
    output logic                 touch_data_out,
    output logic                 touch_busy,
    input  logic [DATA_BITS-1:0] pos_x,
    input  logic [DATA_BITS-1:0] pos_y,
    input  logic [DATA_BITS-1:0] pos_z1,
    input  logic [DATA_BITS-1:0] pos_z2,
    output logic                 cmd_valid,
    output logic [7:0]           last_cmd,
    output logic                 penirq_n
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);

    logic                   dclk_rise, dclk_fall, unused_dclk_level;
    logic [SYNC_STAGES-1:0] csb_sync_q, csb_sync_d;
    logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
    logic                   csb_s, din_s;

    state_t                 state_q, state_d;
    logic [CMD_LEN-2:0]     cmd_sr_q, cmd_sr_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic [CNT_W-1:0]       left_q, left_d;
    logic                   dout_q, dout_d;
    logic                   busy_q, busy_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic [7:0]             last_cmd_q, last_cmd_d;
    logic [CMD_LEN-1:0]     cmd_full;
    logic [DATA_BITS-1:0]   chan_word;

    touch_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dclk_sync (
        .cclk    (cclk),
        .rstb    (rstb),
        .i_async (touch_clk),
        .o_sync  (unused_dclk_level),
        .o_rise  (dclk_rise),
        .o_fall  (dclk_fall)
    );

    // csb resets high so the link looks deselected until it is really sampled
    always_comb begin
        csb_sync_d = {csb_sync_q[SYNC_STAGES-2:0], touch_csb};
        din_sync_d = {din_sync_q[SYNC_STAGES-2:0], touch_data_in};
    end

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            csb_sync_q <= '1;
            din_sync_q <= '0;
        end else begin
            csb_sync_q <= csb_sync_d;
            din_sync_q <= din_sync_d;
        end
    end

    assign csb_s    = csb_sync_q[SYNC_STAGES-1];
    assign din_s    = din_sync_q[SYNC_STAGES-1];
    assign cmd_full = {cmd_sr_q, din_s};

    always_comb begin
        chan_word = '0;
        case (cmd_full[CMD_ADDR_MSB:CMD_ADDR_LSB])
            CH_X:    chan_word = pos_x;
            CH_Y:    chan_word = pos_y;
            CH_Z1:   chan_word = pos_z1;
            CH_Z2:   chan_word = pos_z2;
            default: chan_word = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cmd_sr_d    = cmd_sr_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        left_d      = left_q;
        dout_d      = dout_q;
        busy_d      = busy_q;
        cmd_valid_d = 1'b0;
        last_cmd_d  = last_cmd_q;

        // Deselect overrides any clock edge seen in the same cycle
        if (csb_s) begin
            state_d  = IDLE;
            cmd_sr_d = '0;
            cnt_d    = '0;
            left_d   = '0;
            dout_d   = 1'b0;
            busy_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: state_d = HUNT;
                HUNT: begin
                    if (dclk_rise && din_s) begin
                        cmd_sr_d = 7'h01;
                        cnt_d    = 3'd1;
                        state_d  = CMD;
                    end
                end
                CMD: begin
                    if (dclk_rise) begin
                        cmd_sr_d = cmd_full[CMD_LEN-2:0];
                        cnt_d    = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            last_cmd_d  = cmd_full;
                            cmd_valid_d = 1'b1;
                            data_d      = chan_word;
                            left_d      = cmd_full[CMD_MODE_BIT] ? CNT_W'(8) : CNT_W'(DATA_BITS);
                            state_d     = BUSY_WAIT;
                        end
                    end
                end
                BUSY_WAIT: begin
                    if (dclk_fall) begin
                        busy_d  = 1'b1;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (dclk_fall) begin
                        busy_d  = 1'b0;
                        dout_d  = data_q[DATA_BITS-1];
                        data_d  = {data_q[DATA_BITS-2:0], 1'b0};
                        left_d  = left_q - CNT_W'(1);
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (dclk_fall) begin
                        if (left_q == '0) begin
                            dout_d  = 1'b0;
                            state_d = HUNT;
                        end else begin
                            dout_d = data_q[DATA_BITS-1];
                            data_d = {data_q[DATA_BITS-2:0], 1'b0};
                            left_d = left_q - CNT_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= IDLE;
            cmd_sr_q    <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            left_q      <= '0;
            dout_q      <= 1'b0;
            busy_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            last_cmd_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            cmd_sr_q    <= cmd_sr_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            left_q      <= left_d;
            dout_q      <= dout_d;
            busy_q      <= busy_d;
            cmd_valid_q <= cmd_valid_d;
            last_cmd_q  <= last_cmd_d;
        end
    end

    assign touch_data_out = dout_q;
    assign touch_busy     = busy_q;
    assign cmd_valid      = cmd_valid_q;
    assign last_cmd       = last_cmd_q;

`ifdef TOUCH_PENIRQ_EN
    logic penirq_q, penirq_d;

    // Pen detect is masked while a conversion is in flight, as on the real part
    always_comb begin
        penirq_d = ~(pos_z1 >= PEN_THRESHOLD);
        if (state_q inside {BUSY_WAIT, BUSY, DATA}) begin
            penirq_d = 1'b1;
        end
    end

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            penirq_q <= 1'b1;
        end else begin
            penirq_q <= penirq_d;
        end
    end

    assign penirq_n = penirq_q;
`else
    logic unused_pen_cfg;
    assign unused_pen_cfg = ^PEN_THRESHOLD;
    assign penirq_n       = 1'b1;
`endif

endmodule

`default_nettype wire
